mandelbrot_job_scheduler: RTL and testbench
===========================================

# mandelbrot_job_scheduler

Sequences the per-frame Mandelbrot job and shares a pool of `NUM_CALC` Mandelbrot calculator instances. Pixels are dispatched in raster order with their complex-plane coordinates to whichever calculators are free. Each returned colour is tagged with its originating pixel address and written into the display frame buffer. It sits between the frame-level control (start/done) and the calculator array, and replaces per-pixel address-mapper clock gating with an explicit handshake.

## Interface
Parameters:
- `H_ACTIVE`, 32, pixels per row
- `V_ACTIVE`, 24, rows per frame
- `NUM_CALC`, 2, calculator instances in the pool (1..8)
- `COORD_W`, 32, signed two's-complement fixed-point coordinate width
- `COLOUR_W`, 9, colour word width
- `X_START`, `Y_START`, `X_STEP`, `Y_STEP`: `COORD_W`-bit signed; plane origin (pixel 0,0) and per-pixel steps

Ports:
- `clk` in 1: system clock (25 MHz pixel domain)
- `reset` in 1: synchronous, active-high
- `start` in 1: one-cycle frame request; ignored unless idle
- `busy` out 1: high from first issue cycle until done
- `done` out 1: one-cycle pulse after the last frame-buffer write
- `calc_ready_for_input` in `NUM_CALC`: per-calculator idle flag
- `calc_start` out `NUM_CALC`: one-hot issue pulse
- `calc_real`, `calc_imag` out `COORD_W`: broadcast coordinates, valid with `calc_start`
- `calc_out_ready` in `NUM_CALC`: result valid; held until acked
- `calc_colour` in `NUM_CALC*COLOUR_W`: packed results, calc i at bits [i*COLOUR_W +: COLOUR_W]
- `calc_ack` out `NUM_CALC`: one-hot result accept
- `fb_we` out 1, `fb_addr` out clog2(H_ACTIVE*V_ACTIVE), `fb_data` out `COLOUR_W`: frame-buffer write port

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE -> ISSUE on `start`.
  - ISSUE -> DRAIN after the last pixel is issued.
  - DRAIN -> DONE when no calculator is in flight and the last write is done.
  - DONE -> IDLE after 1 cycle.
- Issue rule:
  - At most one issue per cycle, and only in ISSUE.
  - The target is the lowest-index calc with `calc_ready_for_input`=1 and scheduler in-flight flag=0.
  - On issue, set the in-flight flag and store tag = current pixel address in a per-calc tag register.
- Pixel walk:
  - Raster order, x fastest, address = y*H_ACTIVE + x.
  - `calc_real` = X_START + x*X_STEP, produced incrementally by an adder with no multiplier.
  - At x = H_ACTIVE-1 the next pixel resets x to 0 and real to X_START, increments y, and adds Y_STEP to imag.
  - Arithmetic wraps modulo 2^COORD_W; no saturation.
- Collection rule:
  - Round-robin over `calc_out_ready & in_flight`, starting from the index after the last accepted one.
  - At most one accept per cycle.
  - `calc_ack` is combinational in the accept cycle.
  - The in-flight flag clears at the next edge.
  - `calc_out_ready` for a calc without in-flight set is ignored and never acked.
- Issue and collection run concurrently. A calc acked in cycle t is issuable from cycle t+1, never in t.
- `start` while not IDLE is ignored.
- Reset mid-frame:
  - Next edge: IDLE, all in-flight flags cleared, pixel counters zero.
  - Results still pending in calculators are ignored.

## Timing
- Reset values: `busy`, `done`, `calc_start`, `calc_ack`, `fb_we` = 0; `fb_addr`, `fb_data`, `calc_real`, `calc_imag` = 0.
- `start` sampled in cycle 0.
  - ISSUE from cycle 1, `busy`=1 from cycle 1.
  - First `calc_start` in cycle 1 if calc 0 is ready.
- Write latency: accept in cycle t gives registered `fb_we`/`fb_addr`/`fb_data` in cycle t+1.
- `done` pulses the cycle after the final `fb_we`. `busy` falls in the same cycle as `done`.
- Throughput bounds:
  - Issue is limited to 1 pixel/cycle.
  - Writes are limited to 1/cycle.
  - Frame length ≥ H_ACTIVE*V_ACTIVE + 2 cycles.

## Configuration
- `MANDELBROT_SCHED_FRAME_LOOP_EN`:
  - Defined: DONE -> ISSUE directly, and the pixel walk restarts at (0,0), giving continuous re-render. `busy` stays high except in the DONE cycle, and `start` is needed only for the first frame.
  - Undefined: DONE -> IDLE, and each frame needs a new `start`.

## Test plan
- H=4, V=2, NUM_CALC=1, calculator model returns colour = address after 3 cycles; pulse `start` -> 8 writes, `fb_addr` 0..7 in order, `fb_data` equal to address, then one `done` pulse.
- NUM_CALC=2, calc 1 latency 1 and calc 0 latency 10 -> out-of-order writes, each `fb_data` matches its own tag; all 8 addresses written exactly once.
- Both calcs raise `calc_out_ready` in the same cycle -> one `calc_ack` per cycle, alternating round-robin; no write lost.
- X_START=0x7FFFFFF0, X_STEP=0x10, H=4 -> `calc_real` sequence 0x7FFFFFF0, 0x80000000, 0x80000010, 0x80000020 (wraps), then reloads 0x7FFFFFF0 with imag += Y_STEP at the row change.
- Assert `reset` after 3 issues -> next cycle `busy`=0, all outputs 0; stale `calc_out_ready` gets no ack; a new `start` restarts at address 0.
- With `MANDELBROT_SCHED_FRAME_LOOP_EN`: single `start` -> two consecutive frames, `done` pulses twice, and the second frame's first `fb_addr` is 0.

Source files
------------

// File: rtl/mandelbrot_job_scheduler.sv
// Frame job scheduler: walks pixels in raster order, issues them to a pool of calculators and
// writes tagged results to the frame buffer. Optional MANDELBROT_SCHED_FRAME_LOOP_EN re-renders.
module mandelbrot_job_scheduler #(
    parameter int unsigned H_ACTIVE = 32,
    parameter int unsigned V_ACTIVE = 24,
    parameter int unsigned NUM_CALC = 2,
    parameter int unsigned COORD_W  = 32,
    parameter int unsigned COLOUR_W = 9,
    parameter logic signed [COORD_W-1:0] X_START = '0,
    parameter logic signed [COORD_W-1:0] Y_START = '0,
    parameter logic signed [COORD_W-1:0] X_STEP  = 1,
    parameter logic signed [COORD_W-1:0] Y_STEP  = 1,
    localparam int unsigned NPIX = H_ACTIVE * V_ACTIVE,
    localparam int unsigned AW   = (NPIX > 1) ? $clog2(NPIX) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    input  logic [NUM_CALC-1:0]          calc_ready_for_input,
    output logic [NUM_CALC-1:0]          calc_start,
    output logic [COORD_W-1:0]           calc_real,
    output logic [COORD_W-1:0]           calc_imag,
    input  logic [NUM_CALC-1:0]          calc_out_ready,
    input  logic [NUM_CALC*COLOUR_W-1:0] calc_colour,
    output logic [NUM_CALC-1:0]          calc_ack,
    output logic                         fb_we,
    output logic [AW-1:0]                fb_addr,
    output logic [COLOUR_W-1:0]          fb_data
);
    localparam int unsigned XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int unsigned CW = (NUM_CALC > 1) ? $clog2(NUM_CALC) : 1;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [NUM_CALC-1:0] in_flight_q;
    logic [AW-1:0]       tag_q [NUM_CALC];
    logic [CW-1:0]       rr_q;
    logic [XW-1:0]       x_q;
    logic [AW-1:0]       addr_q;
    logic [COORD_W-1:0]  real_q, imag_q;
    logic                fb_we_q;
    logic [AW-1:0]       fb_addr_q;
    logic [COLOUR_W-1:0] fb_data_q;

    logic                issue_found, issue_en;
    logic [CW-1:0]       issue_idx;
    logic [NUM_CALC-1:0] cand;
    logic                acc_found;
    logic [CW-1:0]       acc_idx, rr_j, rr_next;
    logic                last_pix, x_last, frame_load;

    assign last_pix = (addr_q == AW'(NPIX - 1));
    assign x_last   = (x_q == XW'(H_ACTIVE - 1));

    // Lowest-index calculator that is idle and not already holding one of our pixels.
    always_comb begin
        issue_found = 1'b0;
        issue_idx   = '0;
        for (int i = NUM_CALC - 1; i >= 0; i--) begin
            if (calc_ready_for_input[i] && !in_flight_q[i]) begin
                issue_found = 1'b1;
                issue_idx   = CW'(i);
            end
        end
    end

    assign issue_en = (state_q == StIssue) && issue_found;

    // Round-robin accept, searching from the slot after the last accepted calculator.
    assign cand = calc_out_ready & in_flight_q;
    always_comb begin
        acc_found = 1'b0;
        acc_idx   = '0;
        rr_j      = '0;
        for (int k = 0; k < NUM_CALC; k++) begin
            rr_j = CW'((int'(rr_q) + k) % NUM_CALC);
            if (!acc_found && cand[rr_j]) begin
                acc_found = 1'b1;
                acc_idx   = rr_j;
            end
        end
        rr_next = CW'((int'(acc_idx) + 1) % NUM_CALC);
    end

    always_comb begin
        for (int i = 0; i < NUM_CALC; i++) begin
            calc_start[i] = issue_en && (issue_idx == CW'(i));
            calc_ack[i]   = acc_found && (acc_idx == CW'(i));
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StIssue;
            StIssue: if (issue_en && last_pix) state_d = StDrain;
            StDrain: if (in_flight_q == '0) state_d = StDone;
            StDone: begin
`ifdef MANDELBROT_SCHED_FRAME_LOOP_EN
                state_d = StIssue;
`else
                state_d = StIdle;
`endif
            end
            default: state_d = StIdle;
        endcase
    end

`ifdef MANDELBROT_SCHED_FRAME_LOOP_EN
    assign frame_load = ((state_q == StIdle) && start) || (state_q == StDone);
`else
    assign frame_load = (state_q == StIdle) && start;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            in_flight_q <= '0;
            rr_q        <= '0;
            x_q         <= '0;
            addr_q      <= '0;
            real_q      <= '0;
            imag_q      <= '0;
            fb_we_q     <= 1'b0;
            fb_addr_q   <= '0;
            fb_data_q   <= '0;
            for (int i = 0; i < NUM_CALC; i++) tag_q[i] <= '0;
        end else begin
            state_q <= state_d;
            if (frame_load) begin
                x_q    <= '0;
                addr_q <= '0;
                real_q <= X_START;
                imag_q <= Y_START;
            end else if (issue_en) begin
                tag_q[issue_idx] <= addr_q;
                addr_q           <= addr_q + 1'b1;
                if (x_last) begin
                    x_q    <= '0;
                    real_q <= X_START;
                    imag_q <= imag_q + Y_STEP;
                end else begin
                    x_q    <= x_q + 1'b1;
                    real_q <= real_q + X_STEP;
                end
            end
            // An acked slot is cleared here, so it only becomes issuable next cycle.
            in_flight_q <= (in_flight_q & ~calc_ack) | calc_start;
            if (acc_found) rr_q <= rr_next;
            fb_we_q <= acc_found;
            if (acc_found) begin
                fb_addr_q <= tag_q[acc_idx];
                fb_data_q <= calc_colour[int'(acc_idx)*COLOUR_W +: COLOUR_W];
            end
        end
    end

    assign busy      = (state_q == StIssue) || (state_q == StDrain);
    assign done      = (state_q == StDone);
    assign calc_real = real_q;
    assign calc_imag = imag_q;
    assign fb_we     = fb_we_q;
    assign fb_addr   = fb_addr_q;
    assign fb_data   = fb_data_q;

endmodule

// File: tb/tb_mandelbrot_job_scheduler.sv
// Directed bench for mandelbrot_job_scheduler with a two-slot behavioural calculator pool.
module tb_mandelbrot_job_scheduler;
    logic        clk = 1'b0;
    logic        reset, start;
    logic        busy, done;
    logic [1:0]  rfi, cstart, cor, cack;
    logic [31:0] creal, cimag;
    logic [17:0] ccol;
    logic        fb_we;
    logic [2:0]  fb_addr;
    logic [8:0]  fb_data;

    always #5 clk = ~clk;

    mandelbrot_job_scheduler #(
        .H_ACTIVE(4), .V_ACTIVE(2), .NUM_CALC(2), .COORD_W(32), .COLOUR_W(9),
        .X_START(32'h7FFF_FFF0), .Y_START(32'h0000_0100),
        .X_STEP(32'h0000_0010), .Y_STEP(32'h0000_0020)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .calc_ready_for_input(rfi), .calc_start(cstart), .calc_real(creal),
        .calc_imag(cimag), .calc_out_ready(cor), .calc_colour(ccol), .calc_ack(cack),
        .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data)
    );

    // Calculator model: colour = issue order mod 8, which equals the raster address.
    logic [1:0]  en, pend;
    logic        hold, mclr, lclr;
    int          lat [2];
    int          cnt [2];
    logic [8:0]  col [2];
    int          iss_cnt;
    logic [31:0] rl [16];
    logic [31:0] il [16];

    assign rfi  = en & ~pend;
    assign cor  = {pend[1] && cnt[1] == 0 && !hold, pend[0] && cnt[0] == 0 && !hold};
    assign ccol = {col[1], col[0]};

    always @(posedge clk) begin
        if (mclr) begin
            pend    <= '0;
            iss_cnt <= 0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (cstart[i]) begin
                    pend[i] <= 1'b1;
                    cnt[i]  <= lat[i];
                    col[i]  <= 9'(iss_cnt % 8);
                end else if (pend[i] && cnt[i] > 0) begin
                    cnt[i] <= cnt[i] - 1;
                end else if (pend[i] && cack[i]) begin
                    pend[i] <= 1'b0;
                end
            end
            if (cstart != 2'b00) begin
                iss_cnt <= iss_cnt + 1;
                if (iss_cnt < 16) begin
                    rl[iss_cnt] <= creal;
                    il[iss_cnt] <= cimag;
                end
            end
        end
    end

    // Observation logs of frame-buffer writes, acks and done pulses.
    int         cyc = 0;
    int         wr_n, ack_n, done_n, last_we, done_cyc;
    logic       multi_ack;
    logic [2:0] wa [32];
    logic [8:0] wd [32];
    logic [1:0] al [32];
    int         seen [8];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (lclr) begin
            wr_n <= 0; ack_n <= 0; done_n <= 0; multi_ack <= 1'b0;
            for (int i = 0; i < 8; i++) seen[i] <= 0;
        end else begin
            if (fb_we) begin
                if (wr_n < 32) begin
                    wa[wr_n] <= fb_addr;
                    wd[wr_n] <= fb_data;
                end
                wr_n          <= wr_n + 1;
                seen[fb_addr] <= seen[fb_addr] + 1;
                last_we       <= cyc;
            end
            if (cack != 2'b00) begin
                if (ack_n < 32) al[ack_n] <= cack;
                ack_n <= ack_n + 1;
                if (cack == 2'b11) multi_ack <= 1'b1;
            end
            if (done) begin
                done_n   <= done_n + 1;
                done_cyc <= cyc;
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_all();
        lclr = 1'b1; mclr = 1'b1;
        @(negedge clk);
        lclr = 1'b0; mclr = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (!done && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk({tag, " done seen"}, 64'(done), 64'd1);
    endtask

    task automatic run_frame(input string tag);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(tag);
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_all_once(input string tag);
        chk({tag, " writes"}, 64'(wr_n), 64'd8);
        for (int a = 0; a < 8; a++) begin
            chk({tag, " once"}, 64'(seen[a]), 64'd1);
            chk({tag, " data"}, 64'(wd[a]), 64'(wa[a]));
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; en = 2'b00; hold = 1'b0;
        mclr = 1'b1; lclr = 1'b1; lat[0] = 3; lat[1] = 3;
        repeat (3) @(negedge clk);
        reset = 1'b0; mclr = 1'b0; lclr = 1'b0;

        chk("rst busy", 64'(busy), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst calc_start", 64'(cstart), 64'd0);
        chk("rst calc_ack", 64'(cack), 64'd0);
        chk("rst fb_we", 64'(fb_we), 64'd0);
        chk("rst fb_addr", 64'(fb_addr), 64'd0);
        chk("rst fb_data", 64'(fb_data), 64'd0);
        chk("rst calc_real", 64'(creal), 64'd0);
        chk("rst calc_imag", 64'(cimag), 64'd0);

`ifdef MANDELBROT_SCHED_FRAME_LOOP_EN
        en = 2'b01;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 400 && done_n < 2; k++) @(negedge clk);
        chk("loop done pulses", 64'(done_n), 64'd2);
        chk("loop writes", 64'(wr_n), 64'd16);
        chk("loop frame2 first addr", 64'(wa[8]), 64'd0);
        for (int i = 0; i < 16; i++) chk("loop order", 64'(wa[i]), 64'(i % 8));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("loop reset busy", 64'(busy), 64'd0);
`else
        // Single calculator, latency 3: in-order writes.
        en = 2'b01;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("A busy cycle1", 64'(busy), 64'd1);
        chk("A calc_start cycle1", 64'(cstart), 64'd1);
        chk("A first real", 64'(creal), 64'h7FFF_FFF0);
        chk("A first imag", 64'(cimag), 64'h100);
        wait_done("A");
        chk("A busy at done", 64'(busy), 64'd0);
        @(negedge clk);
        chk("A done one cycle", 64'(done), 64'd0);
        chk("A done count", 64'(done_n), 64'd1);
        chk("A done after last write", 64'(done_cyc - last_we), 64'd1);
        chk("A writes", 64'(wr_n), 64'd8);
        for (int i = 0; i < 8; i++) begin
            chk("A addr order", 64'(wa[i]), 64'(i));
            chk("A data", 64'(wd[i]), 64'(i));
        end
        chk("A real0", 64'(rl[0]), 64'h7FFF_FFF0);
        chk("A real1", 64'(rl[1]), 64'h8000_0000);
        chk("A real2", 64'(rl[2]), 64'h8000_0010);
        chk("A real3", 64'(rl[3]), 64'h8000_0020);
        chk("A real4 reload", 64'(rl[4]), 64'h7FFF_FFF0);
        chk("A imag3", 64'(il[3]), 64'h100);
        chk("A imag4 step", 64'(il[4]), 64'h120);

        // Slow calc 0, fast calc 1: out-of-order completion.
        clr_all();
        en = 2'b11; lat[0] = 10; lat[1] = 1;
        run_frame("B");
        chk("B first write addr", 64'(wa[0]), 64'd1);
        chk_all_once("B");

        // Both results held, then released together.
        clr_all();
        lat[0] = 2; lat[1] = 2; hold = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("C no ack while held", 64'(ack_n), 64'd0);
        hold = 1'b0;
        wait_done("C");
        repeat (2) @(negedge clk);
        chk("C one ack per cycle", 64'(multi_ack), 64'd0);
        chk("C alternate", 64'(al[0] ^ al[1]), 64'd3);
        chk_all_once("C");

        // Reset mid-frame after three issues.
        clr_all();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 100 && iss_cnt < 3; k++) @(negedge clk);
        chk("D three issues", 64'(iss_cnt), 64'd3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("D busy", 64'(busy), 64'd0);
        chk("D calc_start", 64'(cstart), 64'd0);
        chk("D calc_ack", 64'(cack), 64'd0);
        chk("D fb_we", 64'(fb_we), 64'd0);
        chk("D fb_addr", 64'(fb_addr), 64'd0);
        chk("D calc_real", 64'(creal), 64'd0);
        lclr = 1'b1;
        @(negedge clk);
        lclr = 1'b0;
        repeat (20) @(negedge clk);
        chk("D stale pending", 64'(cor != 2'b00), 64'd1);
        chk("D stale not acked", 64'(ack_n), 64'd0);
        chk("D no writes", 64'(wr_n), 64'd0);
        clr_all();
        run_frame("D2");
        chk("D2 restart addr", 64'(wa[0]), 64'd0);
        chk_all_once("D2");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
